mul_arbiter: RTL

Shares one sequential shift-add unsigned multiplier between two requesters. Each requester offers a 32x32 operand pair with a valid/ready handshake. The block grants round-robin, loads and runs the multiplier, and waits for its ready flag. It then returns the 64-bit product, or a timeout error, through a held response handshake. It sits between the two requesters and the multiplier instance.

---
 rtl/mul_arb_pkg.sv | 25 ++
 rtl/mul_arbiter_if.sv | 36 +++
 rtl/mul_arb_rr.sv | 15 +
 rtl/mul_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared types and defaults for the two-port multiplier arbiter.
//   state_t     : arbiter FSM states
//   W_DEF       : default operand width
//   TIMEOUT_DEF : default RUN-cycle budget before a timeout response
//   run_cnt_w() : width of the RUN-cycle counter for a given TIMEOUT
package mul_arb_pkg;

  localparam int W_DEF       = 32;
  localparam int TIMEOUT_DEF = 40;
  localparam int RUN_CNT_W   = $clog2(TIMEOUT_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  // The counter only needs to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice
  // even when TIMEOUT is a power of two.
  function automatic int run_cnt_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the multiplier.
//   req_*  : per-port operand request (valid/ready)
//   resp_* : per-port product response (valid/ready), shared product/err
//   mul_*  : control/data to and from the shared sequential multiplier
// slave  : the arbiter's view; master : the environment's view.
interface mul_arbiter_if #(
  parameter int W = 32
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   req_a0, req_b0, req_a1, req_b1;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [2*W-1:0] resp_product;
  logic           resp_err;
  logic           mul_rst;
  logic           mul_run;
  logic [W-1:0]   mul_multiplicand;
  logic [W-1:0]   mul_multiplier;
  logic           mul_rdy;
  logic [2*W-1:0] mul_product;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
           mul_rdy, mul_product,
    output req_ready, resp_valid, resp_product, resp_err,
           mul_rst, mul_run, mul_multiplicand, mul_multiplier
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
           mul_rdy, mul_product,
    input  req_ready, resp_valid, resp_product, resp_err,
           mul_rst, mul_run, mul_multiplicand, mul_multiplier
  );
endinterface

// File: rtl/mul_arb_rr.sv
// Combinational 2-way round-robin picker.
//   i_valid      : per-port request valid
//   i_last_grant : port served most recently
//   o_sel        : selected port (meaningful only when o_any)
//   o_any        : at least one port is requesting
module mul_arb_rr (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_sel,
  output logic       o_any
);
  assign o_any = |i_valid;
  // On a tie the port that was not served last wins; otherwise the only requester.
  assign o_sel = (&i_valid) ? ~i_last_grant : i_valid[1];
endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential shift-add multiplier between two requesters.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : mul_arbiter_if.slave -- request/response handshakes and the
//         multiplier control/data pins
// Flow: IDLE (round-robin accept) -> LOAD (one mul_rst pulse) -> RUN (step
// until mul_rdy or timeout) -> RESP (hold product/err until resp_ready).
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mul_arbiter_if.slave  bus
);

  localparam int CW = run_cnt_w(TIMEOUT);

  state_t         r_state, w_next;
  logic           r_init;     // high for the first cycle(s) out of reset
  logic           r_gnt, r_last;
  logic [W-1:0]   r_a, r_b;
  logic [2*W-1:0] r_prod;
  logic           r_err;
  logic [CW-1:0]  r_cnt;
  logic           w_sel, w_any, w_acc, w_tmo, w_ack;

  mul_arb_rr u_rr (
    .i_valid     (bus.req_valid),
    .i_last_grant(r_last),
    .o_sel       (w_sel),
    .o_any       (w_any)
  );

  // No accept while the multiplier is still held in its post-reset load pulse.
  assign w_acc = (r_state == IDLE) && !r_init && w_any;
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ack = bus.resp_ready[r_gnt];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (bus.mul_rdy || w_tmo) w_next = RESP;
      RESP:    if (w_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.mul_run    = 1'b0;
    bus.mul_rst    = r_init;
    case (r_state)
      IDLE:    if (w_acc) bus.req_ready[w_sel] = 1'b1;
      LOAD:    bus.mul_rst = 1'b1;
      RUN:     bus.mul_run = 1'b1;
      RESP:    bus.resp_valid[r_gnt] = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_product     = r_prod;
  assign bus.resp_err         = r_err;
  assign bus.mul_multiplicand = r_a;
  assign bus.mul_multiplier   = r_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init <= 1'b1;
      r_gnt  <= 1'b0;
      r_last <= 1'b1;   // port 0 wins the first tie
      r_a    <= '0;
      r_b    <= '0;
      r_prod <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_init <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          r_gnt <= w_sel;
          r_a   <= w_sel ? bus.req_a1 : bus.req_a0;
          r_b   <= w_sel ? bus.req_b1 : bus.req_b0;
        end
        LOAD: r_cnt <= '0;
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          // A ready multiplier beats a timeout landing on the same cycle.
          if (bus.mul_rdy) begin
            r_prod <= bus.mul_product;
            r_err  <= 1'b0;
          end else if (w_tmo) begin
            r_prod <= '0;
            r_err  <= 1'b1;
          end
        end
        RESP: if (w_ack) r_last <= r_gnt;
        default: ;
      endcase
    end
  end

endmodule
